bus_responder: RTL
==================

// Module: bus_responder
// PURPOSE
//  Target (slave) end of the point-to-point request/response link driven by the
//  initiator FSM. Accepts one read/write request at a time into a small local
//  word store, waits a fixed service latency, then returns a response held
//  until the initiator takes it. Mirrors the last committed write data on
//  io_cdata_check so top-level benches can check end-to-end transfer.
// PARAMETERS
//  DATA_W       32  request/response data width
//  ADDR_W        8  request address width, word-addressed
//  DEPTH        16  number of words in local store; legal addr 0..DEPTH-1
//  WAIT_CYCLES   2  cycles spent in WAIT between accept and response (0 allowed)
// PORTS
//  clock           in   1       single clock, rising edge
//  reset           in   1       asynchronous, active-low: 0 = in reset
//  io_req_valid    in   1       initiator presents a request
//  io_req_ready    out  1       responder can accept a request
//  io_req_write    in   1       1 = write, 0 = read
//  io_req_addr     in   ADDR_W  word address
//  io_req_wdata    in   DATA_W  write data
//  io_rsp_valid    out  1       response available
//  io_rsp_ready    in   1       initiator takes response
//  io_rsp_rdata    out  DATA_W  read data (0 for writes and errors)
//  io_rsp_err      out  1       1 = address out of range
//  io_cdata_check  out  DATA_W  data of last successful write
// BEHAVIOUR
//  - Reset (reset==0, async): state IDLE, counter 0, store words all 0,
//    io_req_ready=1, io_rsp_valid=0, io_rsp_rdata=0, io_rsp_err=0,
//    io_cdata_check=0. In-flight transaction discarded; no write commits.
//  - FSM IDLE -> WAIT -> RESP -> IDLE. io_req_ready = (state==IDLE), only.
//  - IDLE: on edge with req_valid&&req_ready latch write/addr/wdata; go WAIT
//    with counter=WAIT_CYCLES-1, or straight to RESP-commit if WAIT_CYCLES==0.
//  - WAIT: exactly WAIT_CYCLES cycles; decrement counter, leave when it is 0.
//  - Commit (edge entering RESP): addr<DEPTH: write -> store[addr]<=wdata,
//    io_cdata_check<=wdata, rdata<=0; read -> rdata<=store[addr].
//    addr>=DEPTH: err<=1, rdata<=0, store and io_cdata_check unchanged.
//  - Latency: io_rsp_valid high WAIT_CYCLES+1 cycles after the accept edge.
//  - RESP: rsp_valid=1; rdata/err stable until rsp_valid&&rsp_ready edge,
//    then IDLE with rsp_valid=0, err=0, rdata=0. Backpressure unbounded.
//  - No request accepted in WAIT/RESP even if req_valid held; a request held
//    through RESP is accepted the cycle after return to IDLE. Max throughput
//    one transaction per WAIT_CYCLES+2 cycles.
//  - Request inputs sampled only on accept edge; later changes ignored.
//  - Counter width $clog2(WAIT_CYCLES+1), min 1; no wrap (reloaded per accept).
// STRUCTURE
//  - bus_pkg: state encoding (IDLE/WAIT/RESP), default DATA_W/ADDR_W,
//    error-code constant, shared with the initiator FSM.
//  - Sub-module responder_mem: DEPTH x DATA_W flop array, one sync write port,
//    one combinational read port, async active-low clear.
//  - Top of this file: FSM, wait counter, request latches, response regs.
// TESTING
//  1 Write addr 3 data 0xDEADBEEF, then read addr 3 -> rsp_valid 3 cycles
//    after each accept; write rdata=0, err=0, cdata_check=0xDEADBEEF;
//    read rdata=0xDEADBEEF.
//  2 Read addr 20 (>=DEPTH) -> err=1, rdata=0; write addr 20 data 0x1234 ->
//    err=1, cdata_check and store unchanged.
//  3 rsp_ready held low 5 cycles -> rsp_valid, rdata, err stable all 5 cycles;
//    req_ready=0 throughout; IDLE one cycle after rsp_ready rises.
//  4 Pull reset low during WAIT of write addr 1 data 0x55 -> all outputs at
//    reset values; later read addr 1 returns 0.
//  5 WAIT_CYCLES=0 build: req_valid held high with rsp_ready=1 -> accept every
//    2nd cycle, rsp_valid one cycle after each accept.
//  6 Change req_addr/wdata during WAIT -> response reflects latched values.

Source files
------------

// File: rtl/bus_pkg.sv
// Definitions shared by both ends of the point-to-point request/response link:
// default widths, FSM state encoding and the response error code.
package bus_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 8;

  localparam logic ERR_NONE       = 1'b0;
  localparam logic ERR_ADDR_RANGE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } bus_state_e;

endpackage

// File: rtl/responder_mem.sv
// Local word store for the responder: flop array with one synchronous write
// port, one combinational read port and an asynchronous active-low clear.
module responder_mem import bus_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Word array: cleared on reset, single write per cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/bus_responder.sv
// Target end of the request/response link: accepts one request at a time,
// waits a fixed service latency, commits to the local store and holds the response.
module bus_responder import bus_pkg::*; #(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_req_valid,
  output logic              io_req_ready,
  input  logic              io_req_write,
  input  logic [ADDR_W-1:0] io_req_addr,
  input  logic [DATA_W-1:0] io_req_wdata,
  output logic              io_rsp_valid,
  input  logic              io_rsp_ready,
  output logic [DATA_W-1:0] io_rsp_rdata,
  output logic              io_rsp_err,
  output logic [DATA_W-1:0] io_cdata_check
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : CNT_ZERO;
  localparam logic ZERO_WAIT = (WAIT_CYCLES == 0);

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return (64'(addr) < 64'(DEPTH));
  endfunction

  bus_state_e        state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              write_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata_r, cdata_r, mem_rdata_s;
  logic              err_r;
  logic              accept_s, commit_s, in_range_s, mem_we_s;
  logic              c_write_s;
  logic [ADDR_W-1:0] c_addr_s;
  logic [DATA_W-1:0] c_wdata_s;

  assign accept_s   = io_req_valid && io_req_ready;
  // With zero latency the commit happens on the accept edge itself, so it must use the live request
  assign commit_s   = (state_r == ST_IDLE && accept_s && ZERO_WAIT) ||
                      (state_r == ST_WAIT && cnt_r == CNT_ZERO);
  assign in_range_s = addr_in_range(c_addr_s);
  assign mem_we_s   = commit_s && c_write_s && in_range_s;

  // Commit operand select: live request in IDLE, latched request otherwise
  always_comb begin
    c_write_s = write_r;
    c_addr_s  = addr_r;
    c_wdata_s = wdata_r;
    if (state_r == ST_IDLE) begin
      c_write_s = io_req_write;
      c_addr_s  = io_req_addr;
      c_wdata_s = io_req_wdata;
    end else begin
      c_write_s = write_r;
      c_addr_s  = addr_r;
      c_wdata_s = wdata_r;
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ZERO_WAIT ? ST_RESP : ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (io_rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    io_req_ready = 1'b0;
    io_rsp_valid = 1'b0;
    case (state_r)
      ST_IDLE: io_req_ready = 1'b1;
      ST_WAIT: io_req_ready = 1'b0;
      ST_RESP: io_rsp_valid = 1'b1;
      default: begin
        io_req_ready = 1'b0;
        io_rsp_valid = 1'b0;
      end
    endcase
  end

  // Request latches and service-latency counter, reloaded on every accept
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      write_r <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      cnt_r   <= CNT_ZERO;
    end else if (accept_s) begin
      write_r <= io_req_write;
      addr_r  <= io_req_addr;
      wdata_r <= io_req_wdata;
      cnt_r   <= CNT_LOAD;
    end else if (state_r == ST_WAIT && cnt_r != CNT_ZERO) begin
      cnt_r   <= cnt_r - CNT_W'(1);
    end
  end

  // Response and mirror registers: loaded at commit, cleared when the response is taken
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata_r <= {DATA_W{1'b0}};
      err_r   <= ERR_NONE;
      cdata_r <= {DATA_W{1'b0}};
    end else if (commit_s) begin
      if (!in_range_s) begin
        err_r   <= ERR_ADDR_RANGE;
        rdata_r <= {DATA_W{1'b0}};
      end else if (c_write_s) begin
        err_r   <= ERR_NONE;
        rdata_r <= {DATA_W{1'b0}};
        cdata_r <= c_wdata_s;
      end else begin
        err_r   <= ERR_NONE;
        rdata_r <= mem_rdata_s;
      end
    end else if (state_r == ST_RESP && io_rsp_ready) begin
      err_r   <= ERR_NONE;
      rdata_r <= {DATA_W{1'b0}};
    end
  end

  assign io_rsp_rdata   = rdata_r;
  assign io_rsp_err     = err_r;
  assign io_cdata_check = cdata_r;

  responder_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clock (clock),
    .reset (reset),
    .we    (mem_we_s),
    .waddr (c_addr_s[IDX_W-1:0]),
    .wdata (c_wdata_s),
    .raddr (c_addr_s[IDX_W-1:0]),
    .rdata (mem_rdata_s)
  );

endmodule
